cube_move_sequencer: RTL and testbench
======================================

Name: cube_move_sequencer

Overview:
- Sequences face-turn commands into the cube-state datapath: one move issued at a time, each waiting for the datapath's completion acknowledge.
- Buffers incoming commands in a FIFO and records completed moves in a history stack for single-step undo.
- Drives the cube datapath's reset, and sits between the user/scramble sources and the cube-state block.

Parameters:
- FIFO_DEPTH, 8, command FIFO entries (power of 2).
- HIST_DEPTH, 16, history entries (power of 2).
- WAIT_TIMEOUT, 1024, max cycles in WAIT before abort.
- CNT_W, 16, move_count width.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !fifo_full.
- cmd_face  in  3  face code: 0 front, 1 back, 2 left, 3 right, 4 top, 5 bottom; 6/7 invalid.
- cmd_rev  in  1  1 = counter-clockwise.
- undo_req  in  1  single-cycle undo pulse.
- clear  in  1  single-cycle clear pulse.
- mv_valid  out  1  one-cycle move strobe to the datapath.
- mv_face  out  3  face for the current move; held from ISSUE through WAIT.
- mv_rev  out  1  direction for the current move; held from ISSUE through WAIT.
- mv_done  in  1  datapath completion acknowledge.
- cube_reset  out  1  one-cycle reset pulse to the datapath.
- busy  out  1  high in any state other than IDLE.
- move_count  out  CNT_W  completed moves, saturating.
- hist_count  out  $clog2(HIST_DEPTH)+1  valid history entries.
- err_invalid  out  1  sticky: an invalid face was received.
- err_timeout  out  1  sticky: a WAIT timed out.

Behaviour:
- Reset (async): FSM=IDLE, FIFO and history empty, all outputs 0.
- Exception: cmd_ready=1 immediately after reset.
- FIFO push: occurs when cmd_valid && cmd_ready at a clock edge.
  - Face 6/7: the command is consumed but not stored, and err_invalid is set.
- FSM states: IDLE, ISSUE, WAIT, CLR.
- IDLE selects work in fixed priority: pending clear > pending undo > FIFO non-empty.
  - Clear selected: go to CLR.
  - Undo selected with history non-empty: load the top history entry with rev inverted; go to ISSUE with src=UNDO.
  - Undo selected with history empty: the undo is dropped with no effect.
  - FIFO non-empty: pop the head entry; go to ISSUE with src=CMD.
- ISSUE: mv_valid=1 for exactly one cycle, then go to WAIT. mv_done is not sampled in ISSUE.
- WAIT: the timer counts from 0.
  - mv_done=1: commit and go to IDLE.
  - Timer reaches WAIT_TIMEOUT-1 without mv_done: set err_timeout, go to IDLE. Nothing is committed and the entry is discarded.
- Commit, src=CMD: push {face,rev} onto history. If history is full, the oldest entry is overwritten and hist_count stays at HIST_DEPTH.
- Commit, src=UNDO: pop history.
- Commit, both sources: move_count += 1, saturating at all-ones.
- CLR: for one cycle, cube_reset=1.
  - FIFO flushed; history, move_count, err_invalid and err_timeout cleared.
  - Then go to IDLE.
- clear and undo_req pulses are latched into pending flags in any state and serviced on the next IDLE.
  - Multiple undo pulses before service collapse to one.
  - A clear arriving while an undo is pending cancels that undo.
- Latency: a command pushed at edge N into an empty FIFO while in IDLE produces mv_valid high in cycle N+2.
  - Back-to-back throughput: one move per (3 + datapath ack latency) cycles.
- Simultaneous events:
  - FIFO push and pop in the same cycle are both honoured.
  - An incoming command during CLR is accepted if cmd_ready=1; the flush applies only to entries present at CLR entry.
- Async reset mid-WAIT aborts immediately; the cube datapath is reset separately by the system reset.

Decomposition:
- Package cube_pkg:
  - typedef face_t (3-bit enum FRONT..BOTTOM).
  - typedef move_t struct {face_t face; logic rev}.
  - constant NUM_FACES=6.
  - function is_valid_face().
- Sub-module move_fifo: a parameterised synchronous FIFO of move_t with full/empty flags, instantiated once.
- The history stack is inline, using a circular pointer and count.

Test Plan:
- Reset, then push {face=0,rev=0} at edge N with mv_done returned 2 cycles after mv_valid -> mv_valid high in cycle N+2 with face=0, rev=0; move_count=1; hist_count=1.
- Push 9 commands back-to-back with mv_done held low -> cmd_ready falls once 8 entries are buffered.
  - After mv_done is released, the 9 moves issue in push order.
  - move_count=9; hist_count=9.
- Commit {3,0}, {4,1}, then pulse undo_req twice before IDLE -> exactly one undo is issued, with mv_face=4, mv_rev=0; hist_count=1; move_count=3.
- Push face=7 -> no mv_valid; err_invalid=1. A following pulse on clear gives cube_reset high for 1 cycle and move_count=0, err_invalid=0, hist_count=0.
- Issue a move with mv_done held low -> err_timeout=1 after WAIT_TIMEOUT cycles in WAIT; busy=0; move_count and hist_count unchanged.
- Commit 17 moves -> hist_count saturates at 16. Then 16 undos issue, with the inverse of the earliest-pushed move overwritten (never issued); a 17th undo produces no mv_valid.

Source files
------------

// File: rtl/cube_pkg.sv
// Shared types for the cube move sequencer: face codes, the move record,
// sequencer FSM states and the face-validity helper.
package cube_pkg;

  localparam int NUM_FACES = 6;

  typedef enum logic [2:0] {
    FRONT  = 3'd0,
    BACK   = 3'd1,
    LEFT   = 3'd2,
    RIGHT  = 3'd3,
    TOP    = 3'd4,
    BOTTOM = 3'd5
  } face_t;

  typedef struct packed {
    face_t face;
    logic  rev;
  } move_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_CLR   = 2'd3
  } seq_state_t;

  // Where the move in flight came from; decides what a commit does to history.
  typedef enum logic {
    SRC_CMD  = 1'b0,
    SRC_UNDO = 1'b1
  } src_t;

  // Codes 6 and 7 do not name a face.
  function automatic logic is_valid_face(input logic [2:0] f);
    return (f < 3'(NUM_FACES));
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous FIFO of move records with full/empty flags and a flush that
// discards the stored entries while still accepting a push in the same cycle.
module move_fifo
  import cube_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  move_t din,
  input  logic  pop,
  input  logic  flush,
  output move_t dout,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  move_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; a flush keeps only a same-cycle push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= do_push ? AW'(1) : '0;
      count  <= do_push ? (AW+1)'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

  // Storage write; lands in slot 0 when it coincides with a flush.
  always_ff @(posedge clk) begin
    if (do_push) mem[flush ? '0 : wr_ptr] <= din;
  end

endmodule

// File: rtl/cube_move_sequencer.sv
// Issues face-turn moves to the cube datapath one at a time, buffering user
// commands in a FIFO and keeping a circular history stack for undo.
//
// Handshakes: cmd_valid/cmd_ready transfer a command on any edge where both
// are high. mv_valid is a one-cycle strobe; the sequencer then waits for a
// single-cycle mv_done (not sampled during the strobe cycle itself), or gives
// up after WAIT_TIMEOUT cycles.
module cube_move_sequencer
  import cube_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int HIST_DEPTH   = 16,
  parameter int WAIT_TIMEOUT = 1024,
  parameter int CNT_W        = 16
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_face,
  input  logic                        cmd_rev,
  input  logic                        undo_req,
  input  logic                        clear,
  output logic                        mv_valid,
  output logic [2:0]                  mv_face,
  output logic                        mv_rev,
  input  logic                        mv_done,
  output logic                        cube_reset,
  output logic                        busy,
  output logic [CNT_W-1:0]            move_count,
  output logic [$clog2(HIST_DEPTH):0] hist_count,
  output logic                        err_invalid,
  output logic                        err_timeout,
  output logic [1:0]                  dbg_state
);

  localparam int HA = $clog2(HIST_DEPTH);
  localparam int TW = $clog2(WAIT_TIMEOUT);

  seq_state_t    state;
  seq_state_t    state_nxt;
  logic          pend_clr;
  logic          pend_undo;
  move_t         cur_move;
  src_t          cur_src;
  logic [TW-1:0] timer;

  move_t         hist_mem [HIST_DEPTH];
  logic [HA-1:0] hist_ptr;
  logic [HA:0]   hist_cnt;
  logic [HA-1:0] hist_top_idx;
  move_t         hist_top;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_flush;
  logic          fifo_full;
  logic          fifo_empty;
  move_t         fifo_din;
  move_t         fifo_dout;
  logic          cmd_take;
  logic          cmd_bad;

  logic          take_clr;
  logic          take_undo;
  logic          load_undo;
  logic          load_cmd;
  logic          commit;
  logic          timeout;

  assign cmd_ready    = !fifo_full;
  assign cmd_take     = cmd_valid && cmd_ready;
  assign cmd_bad      = cmd_take && !is_valid_face(cmd_face);
  assign fifo_push    = cmd_take && is_valid_face(cmd_face);
  assign fifo_din     = '{face: face_t'(cmd_face), rev: cmd_rev};

  assign hist_top_idx = hist_ptr - HA'(1);
  assign hist_top     = hist_mem[hist_top_idx];

  assign busy         = (state != S_IDLE);
  assign mv_face      = cur_move.face;
  assign mv_rev       = cur_move.rev;
  assign hist_count   = hist_cnt;
  assign dbg_state    = state;

  move_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst   (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and strobes: IDLE picks clear, then undo, then queued work.
  always_comb begin
    state_nxt  = state;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    take_clr   = 1'b0;
    take_undo  = 1'b0;
    load_undo  = 1'b0;
    load_cmd   = 1'b0;
    commit     = 1'b0;
    timeout    = 1'b0;
    mv_valid   = 1'b0;
    cube_reset = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_clr) begin
          take_clr  = 1'b1;
          state_nxt = S_CLR;
        end else if (pend_undo) begin
          take_undo = 1'b1;
          if (hist_cnt != '0) begin
            load_undo = 1'b1;
            state_nxt = S_ISSUE;
          end
        end else if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          load_cmd  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mv_valid  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mv_done) begin
          commit    = 1'b1;
          state_nxt = S_IDLE;
        end else if (timer == TW'(WAIT_TIMEOUT - 1)) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_CLR: begin
        cube_reset = 1'b1;
        fifo_flush = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pending request flags: a new pulse always wins over the service that
  // consumes the old one; a clear cancels any undo still waiting.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pend_clr  <= 1'b0;
      pend_undo <= 1'b0;
    end else begin
      if (clear)         pend_clr <= 1'b1;
      else if (take_clr) pend_clr <= 1'b0;
      if (clear)          pend_undo <= 1'b0;
      else if (undo_req)  pend_undo <= 1'b1;
      else if (take_undo) pend_undo <= 1'b0;
    end
  end

  // Move in flight and the WAIT timer, which restarts on every WAIT entry.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cur_move <= '0;
      cur_src  <= SRC_CMD;
      timer    <= '0;
    end else begin
      if (load_undo) begin
        cur_move.face <= hist_top.face;
        cur_move.rev  <= ~hist_top.rev;
        cur_src       <= SRC_UNDO;
      end else if (load_cmd) begin
        cur_move <= fifo_dout;
        cur_src  <= SRC_CMD;
      end
      if (state == S_WAIT) timer <= timer + TW'(1);
      else                 timer <= '0;
    end
  end

  // History pointer/count: commands push (overwriting the oldest when full),
  // undos pop, CLR empties.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      hist_ptr <= '0;
      hist_cnt <= '0;
    end else if (fifo_flush) begin
      hist_ptr <= '0;
      hist_cnt <= '0;
    end else if (commit) begin
      if (cur_src == SRC_CMD) begin
        hist_ptr <= hist_ptr + HA'(1);
        if (hist_cnt != (HA+1)'(HIST_DEPTH)) hist_cnt <= hist_cnt + (HA+1)'(1);
      end else begin
        hist_ptr <= hist_top_idx;
        hist_cnt <= hist_cnt - (HA+1)'(1);
      end
    end
  end

  // History storage write on a committed command.
  always_ff @(posedge CLOCK_50) begin
    if (commit && cur_src == SRC_CMD) hist_mem[hist_ptr] <= cur_move;
  end

  // Saturating move counter and sticky error flags; CLR wipes them, but an
  // error raised in the CLR cycle itself still sticks.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      move_count  <= '0;
      err_invalid <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (fifo_flush)                   move_count <= '0;
      else if (commit && move_count != '1) move_count <= move_count + CNT_W'(1);
      if (cmd_bad)         err_invalid <= 1'b1;
      else if (fifo_flush) err_invalid <= 1'b0;
      if (timeout)         err_timeout <= 1'b1;
      else if (fifo_flush) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cube_move_sequencer.sv
// Directed bench for cube_move_sequencer: a datapath responder acknowledges
// each move after a programmable delay and logs every issued move.
module tb_cube_move_sequencer;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_face;
  logic        cmd_rev;
  logic        undo_req;
  logic        clear;
  logic        mv_valid;
  logic [2:0]  mv_face;
  logic        mv_rev;
  logic        mv_done;
  logic        cube_reset;
  logic        busy;
  logic [15:0] move_count;
  logic [4:0]  hist_count;
  logic        err_invalid;
  logic        err_timeout;
  logic [1:0]  dbg_state;

  int          errors = 0;
  int          checks = 0;
  logic [3:0]  log_q[$];
  logic        ack_en = 1'b1;
  int          ack_lat = 2;
  logic [3:0]  exp2 [9];
  logic [3:0]  exp6 [17];
  logic [3:0]  undo_exp;

  cube_move_sequencer dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_face    (cmd_face),
    .cmd_rev     (cmd_rev),
    .undo_req    (undo_req),
    .clear       (clear),
    .mv_valid    (mv_valid),
    .mv_face     (mv_face),
    .mv_rev      (mv_rev),
    .mv_done     (mv_done),
    .cube_reset  (cube_reset),
    .busy        (busy),
    .move_count  (move_count),
    .hist_count  (hist_count),
    .err_invalid (err_invalid),
    .err_timeout (err_timeout),
    .dbg_state   (dbg_state)
  );

  // Clock.
  always #5 CLOCK_50 = ~CLOCK_50;

  // Datapath model: log each strobe, acknowledge ack_lat cycles later.
  initial begin : responder
    int   age;
    logic pend;
    mv_done = 1'b0;
    pend    = 1'b0;
    age     = 0;
    forever begin
      @(negedge CLOCK_50);
      mv_done = 1'b0;
      if (mv_valid) begin
        log_q.push_back({mv_face, mv_rev});
        pend = 1'b1;
        age  = 0;
      end else if (pend) begin
        age++;
        if (ack_en && age >= ack_lat) begin
          mv_done = 1'b1;
          pend    = 1'b0;
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic push_cmd(input logic [2:0] f, input logic r);
    int tries;
    tries     = 0;
    cmd_face  = f;
    cmd_rev   = r;
    cmd_valid = 1'b1;
    while (!cmd_ready && tries < 3000) begin
      @(negedge CLOCK_50);
      tries++;
    end
    @(negedge CLOCK_50);
    cmd_valid = 1'b0;
    if (tries >= 3000) check("push_accept", 32'(tries), 32'd0);
  endtask

  task automatic wait_quiet(input string tag);
    int q;
    int n;
    q = 0;
    n = 0;
    while (q < 3 && n < 3000) begin
      @(negedge CLOCK_50);
      n++;
      if (busy) q = 0;
      else      q++;
    end
    check(tag, 32'(q >= 3), 32'd1);
  endtask

  task automatic pulse_undo();
    undo_req = 1'b1;
    @(negedge CLOCK_50);
    undo_req = 1'b0;
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    @(negedge CLOCK_50);
    clear = 1'b0;
    check({tag, "_crst_pre"}, 32'(cube_reset), 32'd0);
    @(negedge CLOCK_50);
    check({tag, "_crst_hi"}, 32'(cube_reset), 32'd1);
    check({tag, "_busy_clr"}, 32'(busy), 32'd1);
    @(negedge CLOCK_50);
    check({tag, "_crst_lo"}, 32'(cube_reset), 32'd0);
    check({tag, "_mcount"}, 32'(move_count), 32'd0);
    check({tag, "_hcount"}, 32'(hist_count), 32'd0);
    check({tag, "_einv"}, 32'(err_invalid), 32'd0);
    check({tag, "_etmo"}, 32'(err_timeout), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin : stimulus
    int cnt;
    int n;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_face  = 3'd0;
    cmd_rev   = 1'b0;
    undo_req  = 1'b0;
    clear     = 1'b0;
    exp2 = '{4'b0010, 4'b0101, 4'b0110, 4'b1001, 4'b1010,
             4'b0001, 4'b0011, 4'b0100, 4'b0111};
    for (int i = 0; i < 17; i++) exp6[i] = {3'(i % 6), 1'(i % 3 == 0)};

    // Reset state.
    cyc(3);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_mv_valid", 32'(mv_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mcount", 32'(move_count), 32'd0);
    check("rst_hcount", 32'(hist_count), 32'd0);
    check("rst_errs", {30'd0, err_invalid, err_timeout}, 32'd0);
    check("rst_crst", 32'(cube_reset), 32'd0);
    reset = 1'b0;
    cyc(2);
    check("rst_ready_after", 32'(cmd_ready), 32'd1);

    // Single move: strobe two cycles after the push edge, ack 2 cycles later.
    ack_en    = 1'b1;
    ack_lat   = 2;
    cmd_face  = 3'd0;
    cmd_rev   = 1'b0;
    cmd_valid = 1'b1;
    @(negedge CLOCK_50);
    cmd_valid = 1'b0;
    check("t1_valid_n1", 32'(mv_valid), 32'd0);
    @(negedge CLOCK_50);
    check("t1_valid_n2", 32'(mv_valid), 32'd1);
    check("t1_face", 32'(mv_face), 32'd0);
    check("t1_rev", 32'(mv_rev), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    @(negedge CLOCK_50);
    check("t1_valid_once", 32'(mv_valid), 32'd0);
    wait_quiet("t1_quiet");
    check("t1_mcount", 32'(move_count), 32'd1);
    check("t1_hcount", 32'(hist_count), 32'd1);

    // Nine back-to-back pushes with no acknowledge: FIFO fills at 8.
    do_clear("t2clr");
    log_q.delete();
    ack_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check("t2_ready", 32'(cmd_ready), 32'd1);
      push_cmd(exp2[i][3:1], exp2[i][0]);
    end
    check("t2_full", 32'(cmd_ready), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    ack_en = 1'b1;
    wait_quiet("t2_quiet");
    check("t2_nmoves", 32'(log_q.size()), 32'd9);
    for (int i = 0; i < 9; i++) check("t2_order", 32'(log_q[i]), 32'(exp2[i]));
    check("t2_mcount", 32'(move_count), 32'd9);
    check("t2_hcount", 32'(hist_count), 32'd9);
    check("t2_ready_end", 32'(cmd_ready), 32'd1);

    // Two undo pulses during the last move's WAIT collapse to one undo.
    do_clear("t3clr");
    log_q.delete();
    push_cmd(3'd3, 1'b0);
    wait_quiet("t3_quiet_a");
    push_cmd(3'd4, 1'b1);
    pulse_undo();
    cyc(1);
    pulse_undo();
    wait_quiet("t3_quiet_b");
    check("t3_nmoves", 32'(log_q.size()), 32'd3);
    check("t3_move0", 32'(log_q[0]), 32'h6);
    check("t3_move1", 32'(log_q[1]), 32'h9);
    check("t3_undo", 32'(log_q[2]), 32'h8);
    check("t3_hcount", 32'(hist_count), 32'd1);
    check("t3_mcount", 32'(move_count), 32'd3);

    // Invalid face is swallowed and flagged; clear wipes everything.
    log_q.delete();
    push_cmd(3'd7, 1'b0);
    cyc(4);
    check("t4_nomove", 32'(log_q.size()), 32'd0);
    check("t4_einv", 32'(err_invalid), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_mcount", 32'(move_count), 32'd3);
    check("t4_hcount", 32'(hist_count), 32'd1);
    do_clear("t4clr");

    // Timeout: ISSUE plus WAIT_TIMEOUT WAIT cycles, then abort.
    log_q.delete();
    ack_en = 1'b0;
    push_cmd(3'd2, 1'b0);
    cnt = 0;
    n   = 0;
    while (n < 3000) begin
      @(negedge CLOCK_50);
      n++;
      if (busy) cnt++;
      else if (cnt > 0) break;
    end
    check("t5_busy_cycles", 32'(cnt), 32'd1025);
    check("t5_etmo", 32'(err_timeout), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_mcount", 32'(move_count), 32'd0);
    check("t5_hcount", 32'(hist_count), 32'd0);
    ack_en = 1'b1;
    cyc(3);
    check("t5_late_ack", 32'(move_count), 32'd0);
    do_clear("t5clr");

    // History wrap: 17 commits keep the newest 16; 16 undos, then none.
    log_q.delete();
    for (int i = 0; i < 17; i++) push_cmd(exp6[i][3:1], exp6[i][0]);
    wait_quiet("t6_quiet_fill");
    check("t6_nmoves", 32'(log_q.size()), 32'd17);
    check("t6_mcount", 32'(move_count), 32'd17);
    check("t6_hsat", 32'(hist_count), 32'd16);
    for (int k = 0; k < 16; k++) begin
      pulse_undo();
      wait_quiet("t6_quiet_undo");
      undo_exp = {exp6[16-k][3:1], ~exp6[16-k][0]};
      check("t6_undo_move", 32'(log_q[17+k]), 32'(undo_exp));
    end
    check("t6_hcount_empty", 32'(hist_count), 32'd0);
    pulse_undo();
    wait_quiet("t6_quiet_last");
    check("t6_no_extra_undo", 32'(log_q.size()), 32'd33);
    check("t6_mcount_end", 32'(move_count), 32'd33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
